instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Instruction fetch unit. Produces the 32-bit `instr` word consumed by the decode stage. Keeps the PC and issues word reads to instruction memory, one outstanding at a time. Returned words are buffered in a small prefetch FIFO and presented with a valid/ready handshake. Stops fetching permanently on the decoder's `pc_halt`.

Parameters:
ADDR_W, 16, PC / instruction memory word-address width
DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock
rst_n  in  1  reset
imem_req  out  1  read request to instruction memory
imem_addr  out  ADDR_W  word address of request
imem_ack  in  1  read data valid, single-cycle pulse
imem_rdata  in  32  instruction word, valid with imem_ack
instr  out  32  instruction to decoder
instr_pc  out  ADDR_W  address of instr
instr_valid  out  1  instr holds a fetched word
instr_ready  in  1  decoder accepts instr this cycle
pc_halt  in  1  halt from decoder
halted  out  1  fetch unit is in HALTED state

Behaviour:
- One clock. Reset is synchronous and active-low: `rst_n` low at a `clk` rising edge resets the block.
- Reset values:
  - pc = RESET_PC; state = REQ
  - imem_req = 0; imem_addr = RESET_PC
  - FIFO empty; instr_valid = 0; instr = NOP word (`OPCODE_NOP` in [31:26], rest 0); instr_pc = 0
  - halted = 0
- Reset mid-request: any outstanding response is abandoned, and an imem_ack arriving after reset is ignored.
- States:
  - REQ: if count < DEPTH, assert imem_req with imem_addr = pc for exactly one cycle, then go to WAIT. Otherwise hold in REQ with imem_req = 0.
  - WAIT: imem_req = 0. On imem_ack, push {pc, imem_rdata} into the FIFO, pc <= pc + 1, go to REQ. Memory latency is at least 1 cycle and unbounded.
  - HALTED: imem_req = 0, FIFO held empty, instr_valid = 0, instr = NOP, halted = 1. Left only by reset.
- Credit rule: a request is issued only when the FIFO has a free slot at issue time. The response therefore never overflows the FIFO.
- PC arithmetic: ADDR_W-bit increment by 1, wraps from all-ones to 0 with no flag.
- Output: instr and instr_pc come from the FIFO head. instr_valid = (count != 0).
  - A pop occurs when instr_valid && instr_ready.
  - When empty, instr = NOP and instr_pc holds its last value.
- Simultaneous push and pop: both happen, count is unchanged. A push into an empty FIFO is visible on instr_valid in the next cycle (1-cycle latency from imem_ack to instr_valid).
- pc_halt high at any clock edge, from any state:
  - next state = HALTED, FIFO flushed
  - an outstanding response is discarded when its imem_ack arrives
  - a same-cycle imem_ack is discarded; a same-cycle pop is ignored
- Pointers: read/write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

Optional Feature:
FETCH_REDIRECT_EN:
- When defined, two extra inputs are added: `redirect_valid` (1) and `redirect_pc` (ADDR_W).
- On redirect_valid (not in HALTED):
  - FIFO flushed; pc <= redirect_pc
  - an outstanding request is marked stale and its ack is dropped
  - the next request is issued once the stale ack has returned (state WAIT_STALE), otherwise in the following cycle
- pc_halt and redirect_valid together: pc_halt wins.
- When not defined, the ports are absent and pc only increments.

Test Plan:
- Reset, memory with 1-cycle ack returning 32'h0C000000+addr, instr_ready=1 -> imem_addr 0,1,2,... every 2 cycles; instr sequence matches with instr_pc 0,1,2; halted=0.
- instr_ready=0 for 20 cycles -> exactly DEPTH=4 requests issued, then imem_req stays 0. Release -> words from addr 0..3 delivered in order with no loss.
- RESET_PC=16'hFFFE, ack latency 3 cycles -> addresses FFFE, FFFF, 0000, 0001; latency from imem_ack to instr_valid is 1 cycle.
- pc_halt pulsed while a request is outstanding and 2 entries are buffered -> next cycle instr_valid=0, halted=1, instr=NOP. The late ack is ignored and imem_req stays 0 for 50 cycles.
- rst_n low 1 cycle during WAIT with ack arriving the next cycle -> ack ignored, fresh request at RESET_PC, halted cleared.
- (FETCH_REDIRECT_EN) redirect to 16'h0100 during WAIT -> stale ack dropped, next imem_addr=0100, first delivered instr_pc=0100.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch                                                  |
// | Description : Instruction fetch unit. One outstanding imem read, prefetch  |
// |               FIFO with valid/ready output, permanent halt on pc_halt.     |
// |               Optional redirect ports enabled by FETCH_REDIRECT_EN.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_fetch #(
  parameter int                ADDR_W     = 16,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [5:0]        OPCODE_NOP = 6'h13
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              pc_halt,
`ifdef FETCH_REDIRECT_EN
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
`endif
  output logic              halted
);

  localparam int                PTR_W      = $clog2(DEPTH);
  localparam int                CNT_W      = PTR_W + 1;
  localparam logic [31:0]       c_NOP_WORD = {OPCODE_NOP, 26'd0};
  localparam logic [CNT_W-1:0]  c_FULL     = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_REQ        = 2'd0,
    S_WAIT       = 2'd1,
    S_HALTED     = 2'd2,
    S_WAIT_STALE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;

  logic [31:0]       r_fifo_instr [DEPTH];
  logic [ADDR_W-1:0] r_fifo_pc    [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_last_pc;

  logic              w_empty;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;

  assign w_empty = (r_count == '0);
  assign w_issue = (r_state == S_REQ) && (r_count != c_FULL);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_flush     = 1'b0;

    case (r_state)
      S_REQ: begin
        if (w_issue) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          w_push      = 1'b1;
          w_pc_nxt    = r_pc + ADDR_W'(1);
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT_STALE: begin
        if (imem_ack) begin
          w_state_nxt = S_REQ;
        end
      end
      S_HALTED: begin
        w_flush = 1'b1;
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase

`ifdef FETCH_REDIRECT_EN
    // A request still in flight (or issued this cycle) must have its ack swallowed.
    if (redirect_valid && (r_state != S_HALTED)) begin
      w_flush  = 1'b1;
      w_push   = 1'b0;
      w_pc_nxt = redirect_pc;
      if ((((r_state == S_WAIT) || (r_state == S_WAIT_STALE)) && !imem_ack) || w_issue) begin
        w_state_nxt = S_WAIT_STALE;
      end else begin
        w_state_nxt = S_REQ;
      end
    end
`endif

    if (pc_halt) begin
      w_state_nxt = S_HALTED;
      w_pc_nxt    = r_pc;
      w_flush     = 1'b1;
      w_push      = 1'b0;
    end
  end

  assign w_pop = !w_empty && instr_ready && !w_flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_last_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      // Track the presented pc so instr_pc holds steady once the FIFO drains.
      if (!w_empty) begin
        r_last_pc <= r_fifo_pc[r_rptr];
      end
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wptr] <= imem_rdata;
      r_fifo_pc[r_wptr]    <= r_pc;
    end
  end

  assign imem_req    = rst_n && w_issue;
  assign imem_addr   = r_pc;
  assign instr_valid = !w_empty;
  assign instr       = w_empty ? c_NOP_WORD : r_fifo_instr[r_rptr];
  assign instr_pc    = w_empty ? r_last_pc : r_fifo_pc[r_rptr];
  assign halted      = (r_state == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_fetch                                               |
// | Description : Self-checking bench for instr_fetch with a randomized memory |
// |               responder and an in-order address/delivery scoreboard.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_fetch;

  localparam int          ADDR_W   = 16;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'hFFFA;
  localparam logic [31:0] NOP_WORD = 32'h4C00_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        pc_halt = 1'b0;
  logic        halted;
`ifdef FETCH_REDIRECT_EN
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
`endif

  instr_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_halt(pc_halt),
`ifdef FETCH_REDIRECT_EN
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] q_req[$];
  int          q_req_cyc[$];
  logic [47:0] q_pop[$];
  logic [9:0]  salt = 10'h155;
  int          mem_lat = 1;
  int          mem_lat_max = 0;
  bit          pending = 0;
  int          pend_cnt = 0;
  logic [15:0] pend_addr = '0;
  int          cyc = 0;
  int          n_acks = 0;
  int          max_infl = 0;
  bit          ack_this = 0;
  logic        valid_at_ack = 1'b0;

  function automatic logic [31:0] mem_data(input logic [15:0] a);
    return {6'h03, salt, a};
  endfunction

  function automatic logic [15:0] pc_at(input logic [15:0] base, input int i);
    return base + 16'(i);
  endfunction

  // One clock: observe at the falling edge, answer memory reads, return 1ns after the rising edge.
  task automatic tick();
    int infl;
    bit blk;
    @(negedge clk);
    cyc++;
    infl = q_req.size() - q_pop.size();
    blk = pc_halt;
`ifdef FETCH_REDIRECT_EN
    blk = blk | redirect_valid;
`endif
    if (rst_n && !blk && (instr_valid === 1'b1) && instr_ready)
      q_pop.push_back({instr_pc, instr});
    ack_this   = 0;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (pending) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        imem_ack     = 1'b1;
        imem_rdata   = mem_data(pend_addr);
        pending      = 0;
        n_acks++;
        ack_this     = 1;
        valid_at_ack = instr_valid;
      end
    end
    if (imem_req === 1'b1) begin
      q_req.push_back(imem_addr);
      q_req_cyc.push_back(cyc);
      if (infl + 1 > max_infl) max_infl = infl + 1;
      pending   = 1;
      pend_addr = imem_addr;
      pend_cnt  = (mem_lat_max > 0) ? int'($urandom_range(mem_lat_max, 1)) : mem_lat;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_req.delete();
    q_req_cyc.delete();
    q_pop.delete();
    max_infl = 0;
    n_acks   = 0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    pc_halt     = 1'b0;
    instr_ready = 1'b0;
`ifdef FETCH_REDIRECT_EN
    redirect_valid = 1'b0;
`endif
    tick();
    tick();
    pending  = 0;
    imem_ack = 1'b0;
    rst_n    = 1'b1;
    clear_q();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_ready = 1'b1; pc_halt = 1'b0;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL rst_addr: got %h want %h", imem_addr, RESET_PC); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== NOP_WORD) begin failures++; $display("FAIL rst_instr: got %h want %h", instr, NOP_WORD); end
    checks++; if (instr_pc !== 16'h0000) begin failures++; $display("FAIL rst_instr_pc: got %h want 0000", instr_pc); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted: got %b want 0", halted); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rst_first_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL rst_first_addr: got %h want %h", imem_addr, RESET_PC); end
    pending = 0;
  endtask

  task automatic test_stream();
    int hbad = 0;
    salt = 10'($urandom); mem_lat = 1; mem_lat_max = 0;
    do_reset();
    instr_ready = 1'b1;
    repeat (40) begin
      tick();
      if (halted !== 1'b0) hbad++;
    end
    checks++; if (hbad != 0) begin failures++; $display("FAIL stream_halted: got %0d cycles halted want 0", hbad); end
    checks++; if (q_req.size() != 20) begin failures++; $display("FAIL stream_nreq: got %0d want 20", q_req.size()); end
    checks++; if (q_pop.size() != 19) begin failures++; $display("FAIL stream_npop: got %0d want 19", q_pop.size()); end
    for (int i = 0; i < q_req.size(); i++) begin
      checks++;
      if (q_req[i] !== pc_at(RESET_PC, i)) begin failures++; $display("FAIL stream_addr[%0d]: got %h want %h", i, q_req[i], pc_at(RESET_PC, i)); end
      if (i > 0) begin
        checks++;
        if (q_req_cyc[i] - q_req_cyc[i-1] != 2) begin failures++; $display("FAIL stream_gap[%0d]: got %0d want 2", i, q_req_cyc[i] - q_req_cyc[i-1]); end
      end
    end
    for (int i = 0; i < q_pop.size(); i++) begin
      checks++;
      if (q_pop[i] !== {pc_at(RESET_PC, i), mem_data(pc_at(RESET_PC, i))}) begin
        failures++; $display("FAIL stream_pop[%0d]: got %h want %h", i, q_pop[i], {pc_at(RESET_PC, i), mem_data(pc_at(RESET_PC, i))});
      end
    end
  endtask

  task automatic test_backpressure();
    salt = 10'($urandom); mem_lat = 1; mem_lat_max = 0;
    do_reset();
    repeat (20) tick();
    checks++; if (q_req.size() != DEPTH) begin failures++; $display("FAIL bp_nreq: got %0d want %0d", q_req.size(), DEPTH); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_idle: got %b want 0", imem_req); end
    checks++; if (instr_pc !== RESET_PC) begin failures++; $display("FAIL bp_head_pc: got %h want %h", instr_pc, RESET_PC); end
    instr_ready = 1'b1;
    repeat (30) tick();
    checks++; if (q_pop.size() < DEPTH) begin failures++; $display("FAIL bp_npop: got %0d want >= %0d", q_pop.size(), DEPTH); end
    for (int i = 0; i < q_pop.size(); i++) begin
      checks++;
      if (q_pop[i] !== {pc_at(RESET_PC, i), mem_data(pc_at(RESET_PC, i))}) begin
        failures++; $display("FAIL bp_pop[%0d]: got %h want %h", i, q_pop[i], {pc_at(RESET_PC, i), mem_data(pc_at(RESET_PC, i))});
      end
    end
    checks++; if (max_infl > DEPTH) begin failures++; $display("FAIL bp_credit: got %0d want <= %0d", max_infl, DEPTH); end
  endtask

  task automatic test_latency();
    bit seen = 0;
    salt = 10'($urandom); mem_lat = 3; mem_lat_max = 0;
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (ack_this) seen = 1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL lat_ack_timeout: got none want ack"); end
    checks++; if (valid_at_ack !== 1'b0) begin failures++; $display("FAIL lat_valid_early: got %b want 0", valid_at_ack); end
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL lat_valid: got %b want 1", instr_valid); end
    checks++; if (instr !== mem_data(RESET_PC)) begin failures++; $display("FAIL lat_instr: got %h want %h", instr, mem_data(RESET_PC)); end
    repeat (30) tick();
    checks++; if (q_req.size() < 7) begin failures++; $display("FAIL lat_nreq: got %0d want >= 7", q_req.size()); end
    for (int i = 0; i < q_req.size(); i++) begin
      checks++;
      if (q_req[i] !== pc_at(RESET_PC, i)) begin failures++; $display("FAIL lat_addr[%0d]: got %h want %h", i, q_req[i], pc_at(RESET_PC, i)); end
      if (i > 0) begin
        checks++;
        if (q_req_cyc[i] - q_req_cyc[i-1] != 4) begin failures++; $display("FAIL lat_gap[%0d]: got %0d want 4", i, q_req_cyc[i] - q_req_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_random();
    salt = 10'($urandom); mem_lat_max = 4;
    do_reset();
    repeat (400) begin
      instr_ready = 1'($urandom_range(1, 0));
      tick();
    end
    mem_lat_max = 0;
    checks++; if (q_pop.size() < 20) begin failures++; $display("FAIL rnd_progress: got %0d pops want >= 20", q_pop.size()); end
    checks++; if (max_infl > DEPTH) begin failures++; $display("FAIL rnd_credit: got %0d want <= %0d", max_infl, DEPTH); end
    for (int i = 0; i < q_req.size(); i++) begin
      checks++;
      if (q_req[i] !== pc_at(RESET_PC, i)) begin failures++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, q_req[i], pc_at(RESET_PC, i)); end
    end
    for (int i = 0; i < q_pop.size(); i++) begin
      checks++;
      if (q_pop[i] !== {pc_at(RESET_PC, i), mem_data(pc_at(RESET_PC, i))}) begin
        failures++; $display("FAIL rnd_pop[%0d]: got %h want %h", i, q_pop[i], {pc_at(RESET_PC, i), mem_data(pc_at(RESET_PC, i))});
      end
    end
  endtask

  task automatic test_halt();
    int bad = 0;
    salt = 10'($urandom); mem_lat = 6; mem_lat_max = 0;
    do_reset();
    for (int k = 0; k < 60 && q_req.size() < 3; k++) tick();
    checks++; if (q_req.size() != 3 || n_acks != 2) begin failures++; $display("FAIL halt_setup: got %0d reqs %0d acks want 3 and 2", q_req.size(), n_acks); end
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL halt_pre_valid: got %b want 1", instr_valid); end
    pc_halt = 1'b1; instr_ready = 1'b1;
    tick();
    pc_halt = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL halt_valid: got %b want 0", instr_valid); end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag: got %b want 1", halted); end
    checks++; if (instr !== NOP_WORD) begin failures++; $display("FAIL halt_instr: got %h want %h", instr, NOP_WORD); end
    checks++; if (instr_pc !== RESET_PC) begin failures++; $display("FAIL halt_instr_pc: got %h want %h", instr_pc, RESET_PC); end
    repeat (50) begin
      instr_ready = 1'($urandom_range(1, 0));
      tick();
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL halt_hold: got %0d bad cycles want 0", bad); end
    checks++; if (q_req.size() != 3) begin failures++; $display("FAIL halt_noreq: got %0d reqs want 3", q_req.size()); end
    checks++; if (q_pop.size() != 0) begin failures++; $display("FAIL halt_nopop: got %0d pops want 0", q_pop.size()); end
    do_reset();
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_cleared: got %b want 0", halted); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL halt_restart_req: got %b want 1", imem_req); end
  endtask

  task automatic test_halt_ack();
    mem_lat = 1; mem_lat_max = 0;
    do_reset();
    instr_ready = 1'b1;
    tick();
    pc_halt = 1'b1;
    tick();
    pc_halt = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL haltack_valid: got %b want 0", instr_valid); end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL haltack_flag: got %b want 1", halted); end
    tick(); tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL haltack_later: got %b want 0", instr_valid); end
  endtask

  task automatic test_reset_mid();
    salt = 10'($urandom); mem_lat = 2; mem_lat_max = 0;
    do_reset();
    instr_ready = 1'b1;
    repeat (10) tick();
    for (int k = 0; k < 10 && imem_req !== 1'b1; k++) tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rmid_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL rmid_addr: got %h want %h", imem_addr, RESET_PC); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b want 0", instr_valid); end
    clear_q();
    repeat (30) tick();
    checks++; if (q_pop.size() < 5) begin failures++; $display("FAIL rmid_npop: got %0d want >= 5", q_pop.size()); end
    for (int i = 0; i < q_pop.size(); i++) begin
      checks++;
      if (q_pop[i] !== {pc_at(RESET_PC, i), mem_data(pc_at(RESET_PC, i))}) begin
        failures++; $display("FAIL rmid_pop[%0d]: got %h want %h", i, q_pop[i], {pc_at(RESET_PC, i), mem_data(pc_at(RESET_PC, i))});
      end
    end
  endtask

`ifdef FETCH_REDIRECT_EN
  task automatic test_redirect();
    int mark;
    salt = 10'($urandom); mem_lat = 3; mem_lat_max = 0;
    do_reset();
    instr_ready = 1'b1;
    repeat (9) tick();
    for (int k = 0; k < 10 && imem_req !== 1'b1; k++) tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_req_stale: got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_flush: got %b want 0", instr_valid); end
    mark = cyc;
    clear_q();
    repeat (40) tick();
    checks++; if (q_req.size() < 3 || q_pop.size() < 3) begin failures++; $display("FAIL redir_progress: got %0d reqs %0d pops want >= 3", q_req.size(), q_pop.size()); end
    if (q_req.size() > 0) begin
      checks++; if (q_req_cyc[0] - mark != 3) begin failures++; $display("FAIL redir_first_cyc: got %0d want 3", q_req_cyc[0] - mark); end
    end
    for (int i = 0; i < q_req.size(); i++) begin
      checks++;
      if (q_req[i] !== pc_at(16'h0100, i)) begin failures++; $display("FAIL redir_addr[%0d]: got %h want %h", i, q_req[i], pc_at(16'h0100, i)); end
    end
    for (int i = 0; i < q_pop.size(); i++) begin
      checks++;
      if (q_pop[i] !== {pc_at(16'h0100, i), mem_data(pc_at(16'h0100, i))}) begin
        failures++; $display("FAIL redir_pop[%0d]: got %h want %h", i, q_pop[i], {pc_at(16'h0100, i), mem_data(pc_at(16'h0100, i))});
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_latency();
    test_random();
    test_halt();
    test_halt_ack();
    test_reset_mid();
`ifdef FETCH_REDIRECT_EN
    test_redirect();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
